// File: rtl/ls_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ls_pkg
// Description : Shared constants, state encoding and legality helpers for
//               the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package ls_pkg;

    // RV32I load/store funct3 width codes
    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    localparam int LS_TIMEOUT = 16;
    localparam int LS_CNT_W   = $clog2(LS_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } ls_state_t;

    // Unsigned widths exist only for loads
    function automatic logic f_is_legal(input logic we, input logic [2:0] func3);
        case (func3)
            c_F3_B, c_F3_H, c_F3_W: return 1'b1;
            c_F3_BU, c_F3_HU:       return !we;
            default:                return 1'b0;
        endcase
    endfunction

    function automatic logic f_is_misaligned(input logic [2:0] func3, input logic [1:0] addr_lo);
        case (func3[1:0])
            2'b01:   return addr_lo[0];
            2'b10:   return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : ls_core_if / ls_mem_if
// Description : Core-side request interface and memory-side bus interface
//               of the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface ls_core_if;
    logic        ls_valid;
    logic        ls_we;
    logic [2:0]  ls_func3;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_ready;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic        ls_err;
    logic        stall;

    modport master (
        output ls_valid, ls_we, ls_func3, ls_addr, ls_wdata,
        input  ls_ready, ls_done, ls_rdata, ls_err, stall
    );

    modport slave (
        input  ls_valid, ls_we, ls_func3, ls_addr, ls_wdata,
        output ls_ready, ls_done, ls_rdata, ls_err, stall
    );
endinterface

interface ls_mem_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/ls_align.sv
`default_nettype none
// ============================================================================
// Module      : ls_align
// Description : Store lane replication / byte enables and load lane
//               extraction with sign or zero extension (combinational).
// Revision    : 1.0 - initial release
// ============================================================================
module ls_align
    import ls_pkg::*;
(
    input  wire logic        i_we,
    input  wire logic [2:0]  i_func3,
    input  wire logic [1:0]  i_addr_lo,
    input  wire logic [31:0] i_wdata,
    input  wire logic [31:0] i_rdata,
    output logic      [31:0] o_mem_wdata,
    output logic      [3:0]  o_mem_be,
    output logic      [31:0] o_load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_mem_wdata = i_wdata;
        o_mem_be    = 4'b1111;
        if (i_we) begin
            case (i_func3[1:0])
                2'b00: begin
                    o_mem_wdata = {4{i_wdata[7:0]}};
                    o_mem_be    = 4'b0001 << i_addr_lo;
                end
                2'b01: begin
                    o_mem_wdata = {2{i_wdata[15:0]}};
                    o_mem_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    o_mem_wdata = i_wdata;
                    o_mem_be    = 4'b1111;
                end
            endcase
        end
    end

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr_lo)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            2'd3: w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

        o_load_data = '0;
        case (i_func3)
            c_F3_B:  o_load_data = {{24{w_byte[7]}}, w_byte};
            c_F3_H:  o_load_data = {{16{w_half[15]}}, w_half};
            c_F3_W:  o_load_data = i_rdata;
            c_F3_BU: o_load_data = {24'd0, w_byte};
            c_F3_HU: o_load_data = {16'd0, w_half};
            default: o_load_data = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : RV32I load/store unit: accepts one core request, issues a
//               single word-aligned memory access with timeout, returns data.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import ls_pkg::*;
(
    input  wire logic  clk,
    input  wire logic  rst,
    ls_core_if.slave   core,
    ls_mem_if.master   mem
);

    ls_state_t             r_state;
    logic [LS_CNT_W-1:0]   r_cnt;
    logic                  r_we;
    logic [2:0]            r_func3;
    logic [31:0]           r_addr;
    logic [31:0]           r_wdata;
    logic [31:0]           r_rdata;
    logic                  r_ready;
    logic                  r_done;
    logic                  r_err_flag;
    logic                  r_mem_req;

    logic [31:0]           w_mem_wdata;
    logic [3:0]            w_mem_be;
    logic [31:0]           w_load_data;
    logic                  w_accept_ok;
    logic                  w_in_req;

    // Lane logic works from the captured request so bus outputs stay stable in REQ
    ls_align u_align (
        .i_we        (r_we),
        .i_func3     (r_func3),
        .i_addr_lo   (r_addr[1:0]),
        .i_wdata     (r_wdata),
        .i_rdata     (mem.mem_rdata),
        .o_mem_wdata (w_mem_wdata),
        .o_mem_be    (w_mem_be),
        .o_load_data (w_load_data)
    );

    assign w_accept_ok = f_is_legal(core.ls_we, core.ls_func3) &&
                         !f_is_misaligned(core.ls_func3, core.ls_addr[1:0]);
    assign w_in_req    = (r_state == S_REQ);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_we       <= 1'b0;
            r_func3    <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
            r_err_flag <= 1'b0;
            r_mem_req  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (core.ls_valid) begin
                        r_we    <= core.ls_we;
                        r_func3 <= core.ls_func3;
                        r_addr  <= core.ls_addr;
                        r_wdata <= core.ls_wdata;
                        r_cnt   <= '0;
                        r_rdata <= '0;
                        r_ready <= 1'b0;
                        if (w_accept_ok) begin
                            r_state   <= S_REQ;
                            r_mem_req <= 1'b1;
                        end else begin
                            r_state    <= S_DONE;
                            r_done     <= 1'b1;
                            r_err_flag <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (mem.mem_ack) begin
                        r_state   <= S_DONE;
                        r_mem_req <= 1'b0;
                        r_done    <= 1'b1;
                        r_rdata   <= r_we ? '0 : w_load_data;
                    end else if (r_cnt == LS_CNT_W'(LS_TIMEOUT - 1)) begin
                        r_state    <= S_DONE;
                        r_mem_req  <= 1'b0;
                        r_done     <= 1'b1;
                        r_err_flag <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state    <= S_IDLE;
                    r_done     <= 1'b0;
                    r_err_flag <= 1'b0;
                    r_rdata    <= '0;
                    r_ready    <= 1'b1;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_ready   <= 1'b1;
                    r_done    <= 1'b0;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign core.ls_ready = r_ready;
    assign core.ls_done  = r_done;
    assign core.ls_rdata = r_rdata;
    assign core.ls_err   = r_err_flag;
    assign core.stall    = (core.ls_valid && !r_done) || (r_state != S_IDLE);

    // Bus fields are forced to zero outside REQ so a stale request never leaks
    assign mem.mem_req   = r_mem_req;
    assign mem.mem_we    = w_in_req & r_we;
    assign mem.mem_addr  = w_in_req ? {r_addr[31:2], 2'b00} : '0;
    assign mem.mem_wdata = w_in_req ? w_mem_wdata : '0;
    assign mem.mem_be    = w_in_req ? w_mem_be : 4'b0000;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Scoreboard bench for load_store_unit with a simple memory
//               responder and reset-abort scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ls_core_if core ();
    ls_mem_if  mem ();

    load_store_unit dut (
        .clk  (clk),
        .rst  (rst),
        .core (core),
        .mem  (mem)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          req_n;
        logic        we;
        logic [31:0] maddr;
        logic [3:0]  be;
        logic [31:0] wd;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_tests++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp_v);
        end
    endtask

    function automatic exp_t model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] wdata, input int ack_at, input logic [31:0] word);
        exp_t        e;
        logic        legal;
        logic        mis;
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        mis   = (f3[1:0] == 2'b01 && addr[0]) || (f3[1:0] == 2'b10 && addr[1:0] != 2'b00);
        sh    = word >> (8 * addr[1:0]);
        b     = sh[7:0];
        h     = sh[15:0];
        e.we    = we;
        e.maddr = {addr[31:2], 2'b00};
        e.be    = 4'b1111;
        e.wd    = wdata;
        if (we && f3 == 3'd0) begin
            e.be = 4'b0001 << addr[1:0];
            e.wd = {b_rep(wdata[7:0])};
        end else if (we && f3 == 3'd1) begin
            e.be = addr[1] ? 4'b1100 : 4'b0011;
            e.wd = {wdata[15:0], wdata[15:0]};
        end
        if (!legal || mis) begin
            e.err = 1'b1; e.lat = 1; e.req_n = 0; e.rdata = '0;
        end else if (ack_at == 0) begin
            e.err = 1'b1; e.lat = 17; e.req_n = 16; e.rdata = '0;
        end else begin
            e.err = 1'b0; e.lat = ack_at + 1; e.req_n = ack_at;
            case (f3)
                3'd0:    e.rdata = {{24{b[7]}}, b};
                3'd1:    e.rdata = {{16{h[15]}}, h};
                3'd4:    e.rdata = {24'd0, b};
                3'd5:    e.rdata = {16'd0, h};
                default: e.rdata = word;
            endcase
            if (we) e.rdata = '0;
        end
        return e;
    endfunction

    function automatic logic [31:0] b_rep(input logic [7:0] v);
        return {v, v, v, v};
    endfunction

    // Starts and ends just after a rising edge
    task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input int ack_at, input logic [31:0] word);
        exp_t e;
        int   k;
        int   reqs;
        bit   seen;
        sb.push_back(model(we, f3, addr, wdata, ack_at, word));
        core.ls_valid = 1'b1;
        core.ls_we    = we;
        core.ls_func3 = f3;
        core.ls_addr  = addr;
        core.ls_wdata = wdata;
        mem.mem_rdata = word;
        @(negedge clk);
        check("ready_idle", core.ls_ready, 1);
        check("stall_req", core.stall, 1);
        @(posedge clk);
        #1;
        k = 0; reqs = 0; seen = 0;
        while (!seen && k < 40) begin
            k++;
            @(negedge clk);
            if (mem.mem_req) begin
                reqs++;
                if (reqs == 1) begin
                    check("req_issued", 1, sb[0].req_n != 0);
                    check("mem_addr", mem.mem_addr, sb[0].maddr);
                    check("mem_be", mem.mem_be, sb[0].be);
                    check("mem_we", mem.mem_we, sb[0].we);
                    if (sb[0].we) check("mem_wdata", mem.mem_wdata, sb[0].wd);
                end
                if (reqs == ack_at) mem.mem_ack = 1'b1;
            end
            if (core.ls_done) begin
                seen = 1;
                e = sb.pop_front();
                check("ls_rdata", core.ls_rdata, e.rdata);
                check("ls_err", core.ls_err, e.err);
                check("latency", k, e.lat);
                check("req_cycles", reqs, e.req_n);
            end
            @(posedge clk);
            #1;
            mem.mem_ack = 1'b0;
            if (seen) core.ls_valid = 1'b0;
        end
        if (!seen) begin
            check("done_timeout", 0, 1);
            if (sb.size() > 0) void'(sb.pop_front());
            core.ls_valid = 1'b0;
        end else begin
            @(negedge clk);
            check("done_pulse", core.ls_done, 0);
            check("ready_back", core.ls_ready, 1);
            check("be_idle", mem.mem_be, 0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic late_ack();
        mem.mem_ack = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("late_ack_req", mem.mem_req, 0);
            check("late_ack_done", core.ls_done, 0);
            @(posedge clk);
            #1;
        end
        mem.mem_ack = 1'b0;
    endtask

    task automatic reset_abort();
        core.ls_valid = 1'b1;
        core.ls_we    = 1'b0;
        core.ls_func3 = 3'b010;
        core.ls_addr  = 32'h20;
        @(posedge clk);
        repeat (3) @(negedge clk);
        check("rst_pre_req", mem.mem_req, 1);
        rst = 1'b1;
        core.ls_valid = 1'b0;
        #1;
        check("rst_req_drop", mem.mem_req, 0);
        check("rst_ready", core.ls_ready, 1);
        check("rst_done", core.ls_done, 0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) begin
            @(negedge clk);
            check("rst_no_done", core.ls_done, 0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        core.ls_valid = 1'b0;
        core.ls_we    = 1'b0;
        core.ls_func3 = '0;
        core.ls_addr  = '0;
        core.ls_wdata = '0;
        mem.mem_ack   = 1'b0;
        mem.mem_rdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ls_ready", core.ls_ready, 1);
        check("rst_ls_done", core.ls_done, 0);
        check("rst_ls_err", core.ls_err, 0);
        check("rst_ls_rdata", core.ls_rdata, 0);
        check("rst_mem_req", mem.mem_req, 0);
        check("rst_mem_be", mem.mem_be, 0);
        check("rst_stall", core.stall, 0);
        @(posedge clk);
        #1;

        run_op(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1, 32'h0);
        run_op(1'b1, 3'b000, 32'h13, 32'h000000A5, 1, 32'h0);
        run_op(1'b1, 3'b001, 32'h16, 32'h1234ABCD, 2, 32'h0);
        run_op(1'b0, 3'b000, 32'h21, 32'h0, 1, 32'h80FF7F01);
        run_op(1'b0, 3'b000, 32'h23, 32'h0, 1, 32'h80FF7F01);
        run_op(1'b0, 3'b101, 32'h22, 32'h0, 3, 32'h80FF7F01);
        run_op(1'b0, 3'b001, 32'h22, 32'h0, 1, 32'h80FF7F01);
        run_op(1'b0, 3'b100, 32'h20, 32'h0, 1, 32'h80FF7F01);
        run_op(1'b0, 3'b010, 32'h24, 32'h0, 2, 32'hCAFEF00D);
        run_op(1'b0, 3'b010, 32'h22, 32'h0, 1, 32'h80FF7F01);
        run_op(1'b0, 3'b011, 32'h20, 32'h0, 1, 32'h80FF7F01);
        run_op(1'b1, 3'b100, 32'h20, 32'h55, 1, 32'h0);
        run_op(1'b1, 3'b001, 32'h11, 32'h1234, 1, 32'h0);
        run_op(1'b0, 3'b010, 32'h40, 32'h0, 0, 32'h11112222);
        late_ack();
        reset_abort();
        run_op(1'b0, 3'b010, 32'h20, 32'h0, 2, 32'h80FF7F01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 clk  in  1  core clock; all state changes on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 ls_valid  in  1  core issues load/store this cycle.
REQ-004 ls_we  in  1  1 = store, 0 = load.
REQ-005 ls_func3  in  3  RV32I width code (instruction funct3).
REQ-006 ls_addr  in  32  byte address (ALU result).
REQ-007 ls_wdata  in  32  store data (rs2).
REQ-008 ls_ready  out  1  unit idle, request accepted this cycle.
REQ-009 ls_done  out  1  one-cycle completion pulse.
REQ-010 ls_rdata  out  32  aligned, extended load result; valid only with ls_done.
REQ-011 ls_err  out  1  one-cycle pulse with ls_done: misaligned, illegal func3 or timeout.
REQ-012 stall  out  1  hold PC; high when ls_valid is high and ls_done is low, or when state is not IDLE.
REQ-013 mem_req  out  1  memory request, held until mem_ack.
REQ-014 mem_we  out  1  memory write enable.
REQ-015 mem_addr  out  32  word address, bits [1:0] always 0.
REQ-016 mem_wdata  out  32  lane-replicated store data.
REQ-017 mem_be  out  4  byte enables (bit0 = lane [7:0]).
REQ-018 mem_ack  in  1  memory completion; mem_rdata valid in same cycle.
REQ-019 mem_rdata  in  32  memory read word.

Function
REQ-020 FSM states IDLE, REQ, DONE; transitions only on the clk edge.
REQ-021 IDLE: ls_ready=1; on ls_valid, register we/func3/addr/wdata and go to REQ if legal, else to DONE with the error flag set.
REQ-022 Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; legal stores: 000 SB, 001 SH, 010 SW; all other codes are illegal.
REQ-023 Misaligned: halfword with addr[0]=1, word with addr[1:0]!=0; no mem_req is issued for it.
REQ-024 REQ: mem_req=1, with mem_addr/mem_we/mem_be/mem_wdata stable; on mem_ack, capture mem_rdata and go to DONE.
REQ-025 Timeout: 4-bit counter in REQ; 16 cycles without mem_ack -> drop mem_req, go to DONE with the error flag set.
REQ-026 DONE: ls_done=1 for exactly one cycle, then IDLE; ls_err=1 when the error flag is set.
REQ-027 Minimum latency: accept at edge N, mem_req cycle N+1, ls_done in cycle N+2 when mem_ack arrives in cycle N+1.
REQ-028 Store lanes: SB wdata = {4{wdata[7:0]}}, be = 0001<<addr[1:0]; SH wdata = {2{wdata[15:0]}}, be = 0011 or 1100 by addr[1]; SW be = 1111.
REQ-029 Loads drive mem_be=1111; the result takes lane addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-030 ls_rdata=0 for stores and errors; mem_req=0 and mem_be=0 outside REQ.
REQ-031 ls_valid is ignored outside IDLE; the core holds its request until ls_done.
REQ-032 mem_ack outside REQ is ignored.

Reset
REQ-033 rst forces IDLE, clears the counter, error flag and captured data; outputs reset to ls_ready=1 and all others 0.
REQ-034 Reset asserted during REQ drops mem_req immediately (asynchronous), and no ls_done is produced.

Structure
REQ-035 Shared package ls_pkg holds func3 codes, state encoding and LS_TIMEOUT=16.
REQ-036 One combinational sub-module, ls_align, does lane replication, byte enables, lane extraction and extension.

Verification
REQ-037 SW addr 0x10, wdata 0xDEADBEEF, ack in first REQ cycle -> mem_addr 0x10, be 1111, ls_done at cycle N+2, ls_err 0.
REQ-038 SB addr 0x13, wdata 0x000000A5 -> mem_addr 0x10, be 1000, mem_wdata 0xA5A5A5A5.
REQ-039 mem_rdata 0x80FF7F01 at word 0x20: LB 0x21 -> 0x0000007F; LB 0x23 -> 0xFFFFFF80; LHU 0x22 -> 0x000080FF; LH 0x22 -> 0xFFFF80FF.
REQ-040 LW addr 0x22 or func3 011 -> no mem_req, ls_done and ls_err at N+1, ls_rdata 0.
REQ-041 No mem_ack -> mem_req held 16 cycles, then ls_done and ls_err together; mem_ack arriving later is ignored.
REQ-042 rst pulse in the 3rd REQ cycle -> mem_req 0 immediately, ls_ready 1, no ls_done; the next LW completes normally.
